// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one LAT-stage fmul among NREQ requesters; handshake to rsp_valid is LAT+1 cycles.
// A held result blocks only its owner. Define FMUL_ARB_OVF_EN to build the overflow path.
module fmul_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_y,
    output logic [NREQ-1:0]      rsp_ovf,
    output logic [31:0]          fmul_x1,
    output logic [31:0]          fmul_x2,
    input  logic [31:0]          fmul_y,
    input  logic                 fmul_ovf
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [IDW-1:0] id_t;

    typedef struct packed {
        logic vld;
        id_t  id;
    } tag_t;

    logic [NREQ-1:0] busy;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rel;
    logic            gnt_any;
    id_t             gnt_idx;
    id_t             last;
    tag_t [LAT-1:0]  tag_q;
    logic            cap_vld;
    id_t             cap_id;

    // Index base+off wrapped into 0..NREQ-1; off never exceeds NREQ.
    function automatic id_t rr_idx(input id_t base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return id_t'(sum);
    endfunction

    assign elig = req_valid & ~busy & {NREQ{~rst}};
    assign rel  = rsp_valid & rsp_ready;

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!gnt_any && elig[rr_idx(last, off)]) begin
                gnt_any               = 1'b1;
                gnt_idx               = rr_idx(last, off);
                gnt[rr_idx(last, off)] = 1'b1;
            end
        end
    end

    assign req_ready = gnt;
    assign fmul_x1   = gnt_any ? req_x1[32*int'(gnt_idx) +: 32] : 32'd0;
    assign fmul_x2   = gnt_any ? req_x2[32*int'(gnt_idx) +: 32] : 32'd0;

    // A grant and a release can never hit the same requester in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            last <= id_t'(NREQ - 1);
        end else begin
            busy <= (busy & ~rel) | gnt;
            if (gnt_any) begin
                last <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= {gnt_any, gnt_idx};
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign cap_vld = tag_q[LAT-1].vld;
    assign cap_id  = tag_q[LAT-1].id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_y     <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (cap_vld && cap_id == id_t'(k)) begin
                    rsp_valid[k]       <= 1'b1;
                    rsp_y[32*k +: 32]  <= fmul_y;
                end else if (rel[k]) begin
                    rsp_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef FMUL_ARB_OVF_EN
    // fmul_ovf leads fmul_y by one cycle; one register lines them up.
    logic            ovf_q;
    logic [NREQ-1:0] rsp_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            rsp_ovf_q <= '0;
        end else begin
            ovf_q <= fmul_ovf;
            for (int k = 0; k < NREQ; k++) begin
                if (cap_vld && cap_id == id_t'(k)) begin
                    rsp_ovf_q[k] <= ovf_q;
                end
            end
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = fmul_ovf;
    assign rsp_ovf    = '0;
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: behavioural fmul model, per-requester scoreboard, vector table and directed sequences.
module tb_fmul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;
`ifdef FMUL_ARB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_x1;
    logic [32*NREQ-1:0]  req_x2;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [32*NREQ-1:0]  rsp_y;
    logic [NREQ-1:0]     rsp_ovf;
    logic [31:0]         fmul_x1;
    logic [31:0]         fmul_x2;
    logic [31:0]         fmul_y;
    logic                fmul_ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fmul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_ovf   (rsp_ovf),
        .fmul_x1   (fmul_x1),
        .fmul_x2   (fmul_x2),
        .fmul_y    (fmul_y),
        .fmul_ovf  (fmul_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Truncating single-precision multiply; denormals flush to zero, overflow gives inf.
    function automatic logic [32:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], m};
    endfunction

    logic [31:0] ypipe [LAT];
    logic        opipe [LAT];

    always @(posedge clk) begin
        logic [32:0] r;
        r = fmul_ref(fmul_x1, fmul_x2);
        ypipe[0] <= r[31:0];
        opipe[0] <= r[32];
        for (int i = 1; i < LAT; i++) begin
            ypipe[i] <= ypipe[i-1];
            opipe[i] <= opipe[i-1];
        end
    end

    assign fmul_y   = ypipe[LAT-1];
    assign fmul_ovf = opipe[LAT-2];

    // Scoreboard and per-cycle protocol monitor.
    logic [32:0] exp_q [NREQ][$];
    int          iss_cyc [NREQ];
    logic        prev_v [NREQ];
    logic        prev_r [NREQ];
    logic [31:0] prev_y [NREQ];

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_fmul_x", fmul_x1 | fmul_x2, 0);
            for (int i = 0; i < NREQ; i++) begin
                exp_q[i].delete();
                prev_v[i] = 1'b0;
                prev_r[i] = 1'b0;
            end
        end else begin
            chk("grant_onehot", 32'($countones(req_ready) <= 1), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && !prev_v[i])
                    chk("rsp_latency", 32'(cyc - iss_cyc[i]), LAT + 1);
                if (prev_v[i] && !prev_r[i]) begin
                    chk("hold_valid", 32'(rsp_valid[i]), 1);
                    chk("hold_y", rsp_y[32*i +: 32], prev_y[i]);
                end
                if (req_valid[i] && req_ready[i]) begin
                    exp_q[i].push_back(fmul_ref(req_x1[32*i +: 32], req_x2[32*i +: 32]));
                    iss_cyc[i] = cyc;
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    chk("sb_depth", 32'(exp_q[i].size()), 1);
                    if (exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        chk("sb_y", rsp_y[32*i +: 32], e[31:0]);
                        chk("sb_ovf", 32'(rsp_ovf[i]), 32'(OVF_EN ? e[32] : 1'b0));
                    end
                end
                prev_v[i] = rsp_valid[i];
                prev_r[i] = rsp_ready[i];
                prev_y[i] = rsp_y[32*i +: 32];
            end
        end
    end

    // Returns at the negedge where rsp_valid[idx] is seen; n=0 is the cycle after the grant.
    task automatic wait_rsp(input int idx, output int n);
        int k;
        for (k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid[idx]) break;
            @(posedge clk);
            #1;
        end
        n = k;
        chk("rsp_seen", 32'(rsp_valid[idx]), 1);
    endtask

    typedef struct {
        int          id;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          n;
        int          g;
        int          pg;
        int          ng;
        int          other;
        logic        seen;
        logic [31:0] held;

        vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0};
        vecs[1] = '{1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};
        vecs[2] = '{2, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0};
        vecs[3] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0};
        vecs[4] = '{1, 32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[5] = '{2, 32'h41200000, 32'h41200000, 32'h42C80000, 1'b0};
        vecs[6] = '{3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1};

        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = '1;
        req_x1    = '0;
        req_x2    = '0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_y", 32'(|rsp_y), 0);
        chk("reset_rsp_ovf", 32'(rsp_ovf), 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;

        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            req_x1[32*vecs[v].id +: 32] = vecs[v].x1;
            req_x2[32*vecs[v].id +: 32] = vecs[v].x2;
            @(negedge clk);
            chk("vec_grant", 32'(req_ready), 32'(1) << vecs[v].id);
            chk("vec_fmul_x1", fmul_x1, vecs[v].x1);
            chk("vec_fmul_x2", fmul_x2, vecs[v].x2);
            @(posedge clk); #1;
            req_valid = '0;
            wait_rsp(vecs[v].id, n);
            chk("vec_latency", 32'(n + 1), LAT + 1);
            chk("vec_y", rsp_y[32*vecs[v].id +: 32], vecs[v].y);
            chk("vec_ovf", 32'(rsp_ovf[vecs[v].id]), 32'(OVF_EN ? vecs[v].ovf : 1'b0));
        end

        // Simultaneous requests after reset: pointer starts at NREQ-1.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_x1[32*i +: 32] = 32'h3F800000 + (32'(i) << 23);
            req_x2[32*i +: 32] = 32'h40400000;
        end
        req_valid = '1;
        for (int c = 0; c < NREQ; c++) begin
            @(negedge clk);
            chk("sim_grant", 32'(req_ready), 32'(1) << c);
            @(posedge clk); #1;
            req_valid[c] = 1'b0;
        end
        for (int c = 0; c < NREQ; c++) begin
            @(negedge clk);
            chk("sim_rsp", 32'(rsp_valid), 32'(1) << c);
            @(posedge clk); #1;
        end

        // Backpressure on requester 1.
        rsp_ready = 4'b1101;
        req_valid = 4'b0111;
        wait_rsp(1, n);
        held  = rsp_y[63:32];
        other = 0;
        for (int h = 0; h < 10; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_no_grant", 32'(req_ready[1]), 0);
            chk("bp_valid", 32'(rsp_valid[1]), 1);
            chk("bp_y", rsp_y[63:32], held);
            other += $countones(req_ready & 4'b0101);
        end
        chk("bp_others_issue", 32'(other > 0), 1);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        repeat (6) @(posedge clk);
        #1;
        rsp_ready = '1;
        @(negedge clk);
        chk("bp_release_no_grant", 32'(req_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_regrant", 32'(req_ready), 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;

        // Round-robin: issue 2 then 0, release both together, expect 2 first then alternation.
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = '0;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("rr_first", 32'(req_ready), 4'b0100);
        @(posedge clk); #1;
        req_valid = 4'b0101;
        @(negedge clk);
        chk("rr_second", 32'(req_ready), 4'b0001);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            seen = rsp_valid[0] & rsp_valid[2];
        end
        chk("rr_both_held", 32'(seen), 1);
        @(posedge clk); #1;
        rsp_ready = 4'b0101;
        @(negedge clk);
        chk("rr_release_no_grant", 32'(req_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_pointer", 32'(req_ready), 4'b0100);
        pg = 2;
        ng = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (req_ready != '0) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                chk("rr_alternate", 32'(g != pg), 1);
                pg = g;
                ng++;
            end
        end
        chk("rr_grant_count", 32'(ng >= 8), 1);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (8) @(posedge clk);
        #1;

        // Reset two cycles after issue discards the in-flight result.
        req_x1[31:0] = 32'h40000000;
        req_x2[31:0] = 32'h40400000;
        req_valid    = 4'b0001;
        @(negedge clk);
        chk("mf_grant", 32'(req_ready), 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("mf_rst_no_grant", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            chk("mf_no_rsp", 32'(rsp_valid), 0);
            @(posedge clk); #1;
        end
        req_x1[31:0] = 32'h40400000;
        req_x2[31:0] = 32'h40400000;
        req_valid    = 4'b0001;
        @(negedge clk);
        chk("mf_new_grant", 32'(req_ready), 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(0, n);
        chk("mf_latency", 32'(n + 1), LAT + 1);
        chk("mf_y", rsp_y[31:0], 32'h41100000);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
